// File: rtl/expr_eval_arbiter.sv
// Round-robin sharing of one combinational expression evaluator between NREQ requesters.
// Results travel with their requester id through a fixed-latency pipe into a credit-protected response FIFO.
module expr_eval_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int LAT   = 2,
  parameter  int DEPTH = 4,
  localparam int IDW   = $clog2(NREQ),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*60-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   cfg_mask,
  output logic [59:0]       ev_op,
  output logic              ev_vld,
  input  logic [89:0]       ev_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [89:0]       rsp_data,
  output logic [CW-1:0]     inflight,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload until then, ready may depend combinationally on valid.
  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  ptr_q, ptr_d, gnt_id, ev_id_q;
  logic            found, hs;
  int              idx;
  logic [59:0]     ev_op_q, op_sel;
  logic            ev_vld_q;
  logic [CW-1:0]   inflight_q;

  logic            pipe_vld_q  [LAT];
  logic [IDW-1:0]  pipe_id_q   [LAT];
  logic [89:0]     pipe_data_q [LAT];

  logic [IDW+89:0] fifo_mem_q [DEPTH];
  logic [AW-1:0]   fifo_rd_q, fifo_wr_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic            fifo_wr, fifo_rd;

  function automatic logic [AW-1:0] fifo_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign elig = req_valid & cfg_mask;

  // Grant uses the registered credit count, so a pop in the same cycle does not free a slot yet.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    found     = 1'b0;
    idx       = 0;
    if (!reset && (inflight_q < CW'(DEPTH))) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!found && elig[idx]) begin
          found          = 1'b1;
          req_ready[idx] = 1'b1;
          gnt_id         = IDW'(idx);
        end
      end
    end
  end

  assign hs     = |req_ready;
  assign op_sel = req_op[60*int'(gnt_id) +: 60];
  assign ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  assign fifo_wr = pipe_vld_q[LAT-1];
  assign fifo_rd = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      ev_op_q    <= '0;
      ev_vld_q   <= 1'b0;
      ev_id_q    <= '0;
      inflight_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_id_q[i]   <= '0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      ev_vld_q <= hs;
      if (hs) begin
        ev_op_q <= op_sel;
        ev_id_q <= gnt_id;
        ptr_q   <= ptr_d;
      end
      pipe_vld_q[0]  <= ev_vld_q;
      pipe_id_q[0]   <= ev_id_q;
      pipe_data_q[0] <= ev_result;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_id_q[i]   <= pipe_id_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      if (fifo_wr) begin
        fifo_mem_q[fifo_wr_q] <= {pipe_id_q[LAT-1], pipe_data_q[LAT-1]};
        fifo_wr_q             <= fifo_inc(fifo_wr_q);
      end
      if (fifo_rd) fifo_rd_q <= fifo_inc(fifo_rd_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
      case ({hs, fifo_rd})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign ev_op                = ev_op_q;
  assign ev_vld               = ev_vld_q;
  assign rsp_valid            = (fifo_cnt_q != '0);
  assign {rsp_id, rsp_data}   = rsp_valid ? fifo_mem_q[fifo_rd_q] : '0;
  assign inflight             = inflight_q;
  assign busy                 = (inflight_q != '0);

endmodule

// File: tb/tb_expr_eval_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, credits and response timing/order.
module tb_expr_eval_arbiter;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 32 + 8 + 90;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*60-1:0]  req_op = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     cfg_mask = '1;
  logic [59:0]         ev_op;
  logic                ev_vld;
  logic [89:0]         ev_result;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [89:0]         rsp_data;
  logic [CW-1:0]       inflight;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Expected responses: {cycle rsp becomes visible, id, data}
  logic [EW-1:0] exp_q[$];

  // Stand-in evaluator: six 15-bit fields r_i = a_i*b_i + a_i + b_i + i, a0/b0 in the top slices
  function automatic logic [89:0] eval_fn(input logic [59:0] op);
    logic [89:0] r;
    logic [4:0]  a, b;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      a = op[59-5*i -: 5];
      b = op[29-5*i -: 5];
      r[15*i +: 15] = 15'(int'(a) * int'(b) + int'(a) + int'(b) + i);
    end
    return r;
  endfunction

  assign ev_result = eval_fn(ev_op);

  expr_eval_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .cfg_mask(cfg_mask), .ev_op(ev_op), .ev_vld(ev_vld),
    .ev_result(ev_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  int            ptr_m = 0;
  bit            prev_acc = 0;
  logic [59:0]   prev_op = '0;
  int            g;
  bit            mv;
  logic [NREQ-1:0] er;
  logic [EW-1:0] head;

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", 128'(req_ready), 128'(0));
      exp_q.delete();
      ptr_m    = 0;
      prev_acc = 0;
    end else begin
      g = -1;
      if (exp_q.size() < DEPTH)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(ptr_m + k) % NREQ] && cfg_mask[(ptr_m + k) % NREQ])
            g = (ptr_m + k) % NREQ;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(er));
      chk("ev_vld", 128'(ev_vld), 128'(prev_acc));
      if (prev_acc) chk("ev_op", 128'(ev_op), 128'(prev_op));
      mv = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) <= cyc);
      chk("rsp_valid", 128'(rsp_valid), 128'(mv));
      if (mv) begin
        head = exp_q[0];
        chk("rsp_id", 128'(rsp_id), 128'(head[97:90]));
        chk("rsp_data", 128'(rsp_data), 128'(head[89:0]));
      end
      chk("inflight", 128'(inflight), 128'(exp_q.size()));
      chk("busy", 128'(busy), 128'(exp_q.size() != 0));
      chk("fifo_no_overflow", 128'(dut.fifo_wr && (dut.fifo_cnt_q == CW'(DEPTH))), 128'(0));
      if (mv && rsp_ready) void'(exp_q.pop_front());
      prev_acc = (g >= 0);
      if (g >= 0) begin
        prev_op = req_op[60*g +: 60];
        exp_q.push_back({32'(cyc + LAT + 2), 8'(g), eval_fn(prev_op)});
        ptr_m = (g + 1) % NREQ;
      end
    end
  end

  // Driver: one call = n cycles of the given inputs; ops re-randomized each cycle
  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m,
                       input int rmode, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      req_valid = v;
      cfg_mask  = m;
      rsp_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
      for (int i = 0; i < NREQ; i++) req_op[60*i +: 60] = {$urandom, $urandom};
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ev_op", 128'(ev_op), 128'(0));
    chk("reset_rsp_id", 128'(rsp_id), 128'(0));
    chk("reset_rsp_data", 128'(rsp_data), 128'(0));

    // Single op from requester 0
    @(posedge clk); #1;
    req_valid = 4'b0001; req_op = '0; req_op[59:0] = 60'h123; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (7) @(posedge clk);

    // Fairness, backpressure, masking
    drive(4'b1111, 4'b1111, 1, 20);
    drive(4'b0001, 4'b1111, 0, 10);
    drive(4'b0001, 4'b1111, 1, 10);
    drive(4'b1111, 4'b1010, 1, 10);
    drive(4'b1111, 4'b0001, 1, 8);
    drive(4'b0000, 4'b1111, 1, 8);

    // Randomized traffic with random backpressure and masks
    for (int c = 0; c < 300; c++)
      drive(NREQ'($urandom), ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '1, 2, 1);

    // Reset with ops in flight, then confirm nothing stale and ptr restarts at 0
    drive(4'b0111, 4'b1111, 0, 3);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0; rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    drive(4'b1111, 4'b1111, 1, 6);

    drive(4'b0000, 4'b1111, 1, 20);
    @(negedge clk);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
